// File: rtl/line_buf_ctrl.sv
// Line-buffer writer: streams pixels row by row into NM rotating banks with FREE/FILL/FULL tracking and explicit release.
// Status and read data register one cycle after the event; in_ready drops while the target bank is FULL or no frame is active.
module line_buf_ctrl #(
    parameter int XB      = 10,
    parameter int YB      = 10,
    parameter int PB      = 8,
    parameter int NM      = 4,
    parameter int MINFILL = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [XB-1:0]               cfg_width,
    input  logic [YB-1:0]               cfg_height,
    input  logic                        frame_start,
    input  logic                        in_valid,
    input  logic [PB-1:0]               in_data,
    output logic                        in_ready,
    input  logic [NM-1:0]               mb_release,
    input  logic [NM-1:0][XB-1:0]       mb_rd_addr,
    output logic [NM-1:0][PB-1:0]       mb_rd_data,
    output logic [NM-1:0]               mb_full,
    output logic [NM-1:0]               mb_minfill,
    output logic [NM-1:0][YB-1:0]       mb_row,
    output logic [$clog2(NM)-1:0]       wr_bank,
    output logic                        frame_done
);

    localparam int            BW        = $clog2(NM);
    localparam int            DEPTH     = 1 << XB;
    localparam logic [XB-1:0] MF_COL    = XB'(MINFILL - 1);
    localparam logic [BW-1:0] LAST_BANK = BW'(NM - 1);

    typedef enum logic [1:0] {
        B_FREE,
        B_FILL,
        B_FULL
    } bank_st_e;

    bank_st_e                st_q [NM];
    logic [XB-1:0]           width_q;
    logic [YB-1:0]           height_q;
    logic [XB-1:0]           col_q;
    logic [XB-1:0]           col_d;
    logic [YB-1:0]           row_q;
    logic [BW-1:0]           wr_bank_q;
    logic [BW-1:0]           wr_bank_d;
    logic                    active_q;
    logic [NM-1:0]           full_q;
    logic [NM-1:0]           minfill_q;
    logic [NM-1:0][YB-1:0]   row_tag_q;
    logic [NM-1:0][PB-1:0]   rd_data_q;
    logic                    frame_done_q;
    logic [PB-1:0]           mem_q [NM][DEPTH];
    logic                    accept;
    logic                    row_end;

    assign in_ready  = active_q && (st_q[wr_bank_q] != B_FULL);
    assign accept    = in_valid && in_ready && !frame_start && !rst;
    assign row_end   = (col_q == width_q);
    assign col_d     = row_end ? '0 : col_q + XB'(1);
    assign wr_bank_d = (wr_bank_q == LAST_BANK) ? '0 : wr_bank_q + BW'(1);

    // Bank storage is never cleared; reads return pre-write data on a same-cycle collision.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wr_bank_q][col_q] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NM; i++) begin
                st_q[i] <= B_FREE;
            end
            width_q      <= '0;
            height_q     <= '0;
            col_q        <= '0;
            row_q        <= '0;
            wr_bank_q    <= '0;
            active_q     <= 1'b0;
            full_q       <= '0;
            minfill_q    <= '0;
            row_tag_q    <= '0;
            rd_data_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            for (int i = 0; i < NM; i++) begin
                rd_data_q[i] <= mem_q[i][mb_rd_addr[i]];
            end
            if (frame_start) begin
                width_q   <= cfg_width;
                height_q  <= cfg_height;
                active_q  <= 1'b1;
                wr_bank_q <= '0;
                col_q     <= '0;
                row_q     <= '0;
                full_q    <= '0;
                minfill_q <= '0;
                for (int i = 0; i < NM; i++) begin
                    st_q[i] <= B_FREE;
                end
            end else begin
                // The write bank is never FULL when accepting, so release and accept never collide.
                for (int i = 0; i < NM; i++) begin
                    if (mb_release[i] && st_q[i] == B_FULL) begin
                        st_q[i]      <= B_FREE;
                        full_q[i]    <= 1'b0;
                        minfill_q[i] <= 1'b0;
                    end
                end
                if (accept) begin
                    if (st_q[wr_bank_q] == B_FREE) begin
                        st_q[wr_bank_q]      <= B_FILL;
                        row_tag_q[wr_bank_q] <= row_q;
                    end
                    if (col_q == MF_COL) begin
                        minfill_q[wr_bank_q] <= 1'b1;
                    end
                    col_q <= col_d;
                    if (row_end) begin
                        st_q[wr_bank_q]      <= B_FULL;
                        full_q[wr_bank_q]    <= 1'b1;
                        minfill_q[wr_bank_q] <= 1'b1;
                        row_q                <= row_q + YB'(1);
                        wr_bank_q            <= wr_bank_d;
                        if (row_q == height_q) begin
                            frame_done_q <= 1'b1;
                            active_q     <= 1'b0;
                        end
                    end
                end
            end
        end
    end

    assign mb_rd_data = rd_data_q;
    assign mb_full    = full_q;
    assign mb_minfill = minfill_q;
    assign mb_row     = row_tag_q;
    assign wr_bank    = wr_bank_q;
    assign frame_done = frame_done_q;

endmodule

// File: doc/line_buf_ctrl.md
Name: line_buf_ctrl

Overview:
Parametrised line-buffer controller that writes an incoming pixel stream row by row into NM internal line banks, rotating over the banks in order. It tracks per-bank FREE/FILL/FULL state, flags each bank as min-filled or full, and frees a bank only on an explicit release. It sits between the input interface FIFO and the convolution control unit and generalises the 4-bank fixed writer to any NM ≥ 2, with a programmable min-fill threshold, a valid/ready handshake and frame sequencing.

Parameters:
XB, 10, column index width
YB, 10, row index width
PB, 8, pixel width
NM, 4, number of line banks, any value ≥ 2, not restricted to a power of 2
MINFILL, 3, pixels written before mb_minfill asserts, 1..2^XB

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
cfg_width  in  XB  last column index (row length minus 1), sampled at frame_start
cfg_height  in  YB  last row index, sampled at frame_start
frame_start  in  1  one-cycle pulse that starts or restarts a frame
in_valid  in  1  input pixel valid
in_data  in  PB  input pixel
in_ready  out  1  pixel accepted when in_valid && in_ready
mb_release  in  NM  per-bank release from the control unit
mb_rd_addr  in  NM x XB  per-bank read address
mb_rd_data  out  NM x PB  per-bank read data
mb_full  out  NM  bank holds a complete row
mb_minfill  out  NM  bank holds at least MINFILL pixels of the current row
mb_row  out  NM x YB  row index held by the bank
wr_bank  out  clog2(NM)  bank currently being written
frame_done  out  1  one-cycle pulse after the last pixel of a frame

Behaviour:
- Reset, synchronous, evaluated in a clk edge: all banks FREE; wr_bank=0; col=0; row=0; active=0; in_ready=0; mb_full=0; mb_minfill=0; mb_row=0; frame_done=0; mb_rd_data=0. Bank contents are not cleared.
- frame_start (rst low): latch cfg_width and cfg_height; set active=1, wr_bank=0, col=0, row=0; all banks FREE; clear mb_full and mb_minfill. frame_start takes priority over an accept or release in the same cycle, and mid-frame it aborts the current frame.
- in_ready is combinational: active && state[wr_bank]!=FULL.
- Accept: mem[wr_bank][col] <= in_data.
  - If the bank is FREE: it moves to FILL and mb_row[wr_bank] <= row.
  - col==MINFILL-1: mb_minfill[wr_bank] <= 1 in the next cycle.
  - col==cfg_width: the bank moves to FULL and mb_full and mb_minfill are set (this covers MINFILL > width). col <= 0, row <= row+1, and wr_bank <= (wr_bank==NM-1) ? 0 : wr_bank+1.
  - Otherwise: col <= col+1.
- End of frame: the accept with col==cfg_width and row==cfg_height pulses frame_done for one cycle and clears active. in_ready stays 0 until the next frame_start. Bank states persist.
- Release: mb_release[i] with state[i]==FULL sets bank i to FREE and clears mb_full[i] and mb_minfill[i] in the next cycle. A release in FREE or FILL state is ignored.
- Release of the bank at wr_bank in the same cycle as in_valid: no accept that cycle because the bank is still FULL; in_ready rises the following cycle.
- Several releases in one cycle are all honoured.
- Reads: mb_rd_data[i] <= mem[i][mb_rd_addr[i]], one-cycle latency, independent per bank. A read of an address being written in the same cycle returns the old data.
- Backpressure: if all NM banks are FULL, in_ready stays 0 until a release.

Test Plan:
- NM=4, width=8 (cfg_width=7), height=4 (cfg_height=3), in_valid held high, each bank released 2 cycles after it goes full -> pixels land in banks 0,1,2,3 in order; mb_row = 0,1,2,3; mb_minfill rises the cycle after col 2 is accepted; frame_done pulses once after 32 accepts.
- NM=3, cfg_height=5, no releases -> in_ready drops after 3 rows; releasing bank 0 lets row 3 go to bank 0 with mb_row[0]=3, so wr_bank wraps 2->0 at a non-power-of-2 NM.
- Release of wr_bank issued in the same cycle as in_valid while that bank is FULL -> no accept that cycle, accept in the next cycle; mb_full clears after exactly one cycle.
- frame_start at row 1, col 4 -> all mb_full and mb_minfill clear the next cycle; wr_bank=0 and the next pixel is written to bank 0 at col 0.
- Read bank 1 at address 5 after it fills with data equal to col -> mb_rd_data[1]=5 one cycle later. A release of a FILL bank leaves its state unchanged.
- rst asserted mid-row -> all outputs at their reset values on the next edge; in_ready=0 until frame_start.
